pc_fetch_unit: RTL

//  Program-counter and fetch-sequencing stage directly upstream of Datapath.

---
 rtl/pc_fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Purpose : program counter and fetch sequencer feeding the datapath's instruction address.
// Latency : a redirect decoded in cycle N drives PC at the edge ending cycle N, so there are no bubbles and no delay slot.
// Backpressure: i_stall holds PC and drops fetch-valid; i_halt freezes the unit until reset.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_stall          hold PC this cycle (RUN -> STALL)
//   i_halt           halt request; enters HALT, leaves only through reset
//   i_branch         BEQ decode from the control unit
//   i_zero           ALU zero flag for the current instruction
//   i_branch_offset  sign-extended, pre-scaled branch offset (bit 0 ignored)
//   i_jump           jump decode from the control unit
//   i_jump_addr      jump field, instruction[11:0]
//   o_pc             current PC (instruction memory address)
//   o_pc_plus2       o_pc + PC_STEP, combinational link value
//   o_fetch_valid    PC addresses a valid instruction this cycle
//   o_halted         unit is in HALT
//   o_trap           one-cycle pulse while PC holds TRAP_PC after a bounds hit
//
// Build option PC_BOUNDS_EN: when it is defined, any next PC computed in RUN
// that is at or beyond IMEM_BYTES is replaced by TRAP_PC and o_trap pulses.
// When it is not defined, there is no compare logic, o_trap is tied low and
// the PC wraps modulo 2^16.

module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd2
`ifdef PC_BOUNDS_EN
    ,
    parameter logic [15:0] IMEM_BYTES = 16'd512,
    parameter logic [15:0] TRAP_PC    = 16'h00F0
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic [15:0] i_branch_offset,
    input  logic        i_jump,
    input  logic [11:0] i_jump_addr,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_plus2,
    output logic        o_fetch_valid,
    output logic        o_halted,
    output logic        o_trap
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_fetch_valid;
    logic        r_halted;

    logic [15:0] w_pc_plus2;
    logic [15:0] w_jump_target;
    logic [15:0] w_branch_target;
    logic        w_branch_taken;
    logic [15:0] w_redirect_pc;
    logic [15:0] w_next_pc;

    // All arithmetic is 16-bit and wraps silently.
    assign w_pc_plus2 = r_pc + PC_STEP;

    // The jump keeps the 8 KiB region of the sequential PC. The 12-bit field
    // is a halfword index.
    assign w_jump_target = {w_pc_plus2[15:13], i_jump_addr, 1'b0};

    // Masking after the add keeps PC even. This is exact: PC+2 is even, so
    // offset bit 0 cannot carry into bit 1.
    assign w_branch_target = (w_pc_plus2 + i_branch_offset) & 16'hFFFE;

    assign w_branch_taken = i_branch & i_zero;

    // A jump overrides a taken branch. A branch that is not taken falls through.
    always_comb begin
        w_redirect_pc = w_pc_plus2;
        if (i_jump) begin
            w_redirect_pc = w_jump_target;
        end else if (w_branch_taken) begin
            w_redirect_pc = w_branch_target;
        end
    end

`ifdef PC_BOUNDS_EN
    logic w_out_of_bounds;
    logic r_trap;

    assign w_out_of_bounds = (w_redirect_pc >= IMEM_BYTES);
    assign w_next_pc       = w_out_of_bounds ? TRAP_PC : w_redirect_pc;
`else
    assign w_next_pc = w_redirect_pc;
`endif

    // State, PC and status outputs all live in one registered process. The
    // outputs therefore change on the same edge as the state that defines them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
`ifdef PC_BOUNDS_EN
            r_trap        <= 1'b0;
`endif
        end else begin
`ifdef PC_BOUNDS_EN
            // The trap pulse is high only in the cycle where PC equals TRAP_PC.
            r_trap <= 1'b0;
`endif
            case (r_state)
                S_BOOT: begin
                    // Spend one cycle at RESET_PC without fetching, then run.
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end

                S_RUN: begin
                    if (i_halt) begin
                        r_state       <= S_HALT;
                        r_fetch_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end else if (i_stall) begin
                        r_state       <= S_STALL;
                        r_fetch_valid <= 1'b0;
                    end else begin
                        r_pc          <= w_next_pc;
                        r_fetch_valid <= 1'b1;
`ifdef PC_BOUNDS_EN
                        r_trap        <= w_out_of_bounds;
`endif
                    end
                end

                S_STALL: begin
                    // The exit cycle only re-enters RUN. Redirect inputs are
                    // ignored here and sampled again once PC is being fetched.
                    if (i_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (!i_stall) begin
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end

                S_HALT: begin
                    // Terminal state. Only reset leaves it.
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end

                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus2    = w_pc_plus2;
    assign o_fetch_valid = r_fetch_valid;
    assign o_halted      = r_halted;
`ifdef PC_BOUNDS_EN
    assign o_trap        = r_trap;
`else
    assign o_trap        = 1'b0;
`endif

endmodule
